// File: rtl/spectrum_bar_renderer_if.sv
// Bus bundle between the spectrum bar renderer, its bin store and the framebuffer write port.
// The master modport is the renderer side. The slave modport is the bin store, framebuffer and control side.
interface spectrum_bar_renderer_if #(
    parameter int ADDR_WIDTH = 19,
    parameter int NUM_BARS   = 16,
    parameter int MAG_WIDTH  = 10
);
    logic                        start;
    logic                        busy;
    logic                        done;
    logic                        bin_rd_en;
    logic [$clog2(NUM_BARS)-1:0] bin_rd_addr;
    logic [MAG_WIDTH-1:0]        bin_rd_data;
    logic                        wr_en;
    logic [ADDR_WIDTH-1:0]       wr_addr;
    logic                        wr_data;

    modport master (
        input  start, bin_rd_data,
        output busy, done, bin_rd_en, bin_rd_addr, wr_en, wr_addr, wr_data
    );

    modport slave (
        output start, bin_rd_data,
        input  busy, done, bin_rd_en, bin_rd_addr, wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/spectrum_bar_renderer.sv
// Redraws a 1-bit framebuffer as NUM_BARS vertical bars, one pixel per clock, column-major.
// Optional macro RENDER_PEAK_EN adds decaying peak-hold markers above each bar.
module spectrum_bar_renderer #(
    parameter int SCREEN_WIDTH  = 640,
    parameter int SCREEN_HEIGHT = 480,
    parameter int ADDR_WIDTH    = $clog2(SCREEN_WIDTH*SCREEN_HEIGHT),
    parameter int NUM_BARS      = 16,
    parameter int BAR_GAP       = 1,
    parameter int MAG_WIDTH     = 10
) (
    input logic wrclk,
    input logic reset,
    spectrum_bar_renderer_if.master bus
);
    localparam int BAR_W    = SCREEN_WIDTH / NUM_BARS;
    localparam int BARS_END = NUM_BARS * BAR_W;
    localparam int XW       = $clog2(SCREEN_WIDTH);
    localparam int YW       = $clog2(SCREEN_HEIGHT);
    localparam int BW       = $clog2(NUM_BARS);
    localparam int CW       = $clog2(BAR_W);

    localparam logic [XW-1:0] X_LAST   = XW'(SCREEN_WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST   = YW'(SCREEN_HEIGHT - 1);
    localparam logic [CW-1:0] COL_LAST = CW'(BAR_W - 1);

    typedef enum logic [2:0] {IDLE, FETCH, LATCH, DRAW, DONE} state_t;

    state_t                state;
    state_t                next_state;
    logic [XW-1:0]         x;
    logic [YW-1:0]         y;
    logic [BW-1:0]         bar;
    logic [CW-1:0]         col;
    logic [ADDR_WIDTH-1:0] addr;
    logic [MAG_WIDTH-1:0]  mag;
    logic [MAG_WIDTH-1:0]  mag_clamped;
    logic                  col_end;
    logic                  last_col;
    logic                  next_bar;
    logic                  in_bar;
    logic                  bar_lit;
    logic                  peak_lit;

    // col tracks x mod BAR_W incrementally so the gap test needs no divider.
    always_comb begin
        mag_clamped = (32'(bus.bin_rd_data) > 32'(SCREEN_HEIGHT)) ?
                      MAG_WIDTH'(SCREEN_HEIGHT) : bus.bin_rd_data;
        col_end     = (y == Y_LAST);
        last_col    = (x == X_LAST);
        next_bar    = (col == COL_LAST) && (32'(x) + 32'd1 < 32'(BARS_END));
        in_bar      = (32'(x) < 32'(BARS_END)) && (32'(col) < 32'(BAR_W - BAR_GAP));
        bar_lit     = (32'(y) + 32'(mag) >= 32'(SCREEN_HEIGHT));
    end

`ifdef RENDER_PEAK_EN
    logic [MAG_WIDTH-1:0] peak [NUM_BARS];
    logic [MAG_WIDTH-1:0] peak_dec;
    logic [MAG_WIDTH-1:0] peak_next;

    always_comb begin
        peak_dec  = (peak[bar] == '0) ? '0 : peak[bar] - MAG_WIDTH'(1);
        peak_next = (mag_clamped > peak_dec) ? mag_clamped : peak_dec;
        peak_lit  = (peak[bar] != '0) &&
                    (32'(y) + 32'(peak[bar]) == 32'(SCREEN_HEIGHT));
    end

    // Each bar's peak decays by one per frame unless the new magnitude beats it.
    always_ff @(posedge wrclk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_BARS; i++) begin
                peak[i] <= '0;
            end
        end else if (state == LATCH) begin
            peak[bar] <= peak_next;
        end
    end
`else
    assign peak_lit = 1'b0;
`endif

    always_ff @(posedge wrclk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (bus.start) next_state = FETCH;
            FETCH:   next_state = LATCH;
            LATCH:   next_state = DRAW;
            DRAW: begin
                if (col_end) begin
                    if (last_col) begin
                        next_state = DONE;
                    end else if (next_bar) begin
                        next_state = FETCH;
                    end
                end
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Address steps by one row per pixel and restarts at x+1 at column end, so no multiplier.
    always_ff @(posedge wrclk or posedge reset) begin
        if (reset) begin
            x    <= '0;
            y    <= '0;
            bar  <= '0;
            col  <= '0;
            addr <= '0;
            mag  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        x    <= '0;
                        y    <= '0;
                        bar  <= '0;
                        col  <= '0;
                        addr <= '0;
                    end
                end
                LATCH: mag <= mag_clamped;
                DRAW: begin
                    if (col_end) begin
                        y    <= '0;
                        addr <= ADDR_WIDTH'(x) + ADDR_WIDTH'(1);
                        if (!last_col) begin
                            x   <= x + XW'(1);
                            col <= (col == COL_LAST) ? '0 : col + CW'(1);
                            if (next_bar) begin
                                bar <= bar + BW'(1);
                            end
                        end
                    end else begin
                        y    <= y + YW'(1);
                        addr <= addr + ADDR_WIDTH'(SCREEN_WIDTH);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy        = (state != IDLE);
    assign bus.done        = (state == DONE);
    assign bus.bin_rd_en   = (state == FETCH);
    assign bus.bin_rd_addr = bar;
    assign bus.wr_en       = (state == DRAW);
    assign bus.wr_addr     = addr;
    assign bus.wr_data     = (state == DRAW) && in_bar && (bar_lit || peak_lit);
endmodule

// File: tb/tb_spectrum_bar_renderer.sv
// Randomized self-checking bench for spectrum_bar_renderer: 8x4 and 10x4 screens, two bars each,
// compared cycle by cycle against a frame schedule and image computed from the bar rules.
module tb_spectrum_bar_renderer;
    localparam int H   = 4;
    localparam int NB  = 2;
    localparam int GAP = 1;
    localparam int MW  = 4;
    localparam int WA  = 8;
    localparam int WB  = 10;
    localparam int AWA = $clog2(WA*H);
    localparam int AWB = $clog2(WB*H);
    localparam int MAXC = 64;

    logic wrclk = 1'b0;
    logic reset;

    always #5 wrclk = ~wrclk;

    spectrum_bar_renderer_if #(.ADDR_WIDTH(AWA), .NUM_BARS(NB), .MAG_WIDTH(MW)) bus_a ();
    spectrum_bar_renderer_if #(.ADDR_WIDTH(AWB), .NUM_BARS(NB), .MAG_WIDTH(MW)) bus_b ();

    spectrum_bar_renderer #(
        .SCREEN_WIDTH(WA), .SCREEN_HEIGHT(H), .ADDR_WIDTH(AWA),
        .NUM_BARS(NB), .BAR_GAP(GAP), .MAG_WIDTH(MW)
    ) dut_a (
        .wrclk(wrclk),
        .reset(reset),
        .bus(bus_a)
    );

    spectrum_bar_renderer #(
        .SCREEN_WIDTH(WB), .SCREEN_HEIGHT(H), .ADDR_WIDTH(AWB),
        .NUM_BARS(NB), .BAR_GAP(GAP), .MAG_WIDTH(MW)
    ) dut_b (
        .wrclk(wrclk),
        .reset(reset),
        .bus(bus_b)
    );

    int bins_a [NB];
    int bins_b [NB];
    int peaks_a [NB];
    int peaks_b [NB];

    int checks = 0;
    int errors = 0;

    int e_wen    [MAXC];
    int e_addr   [MAXC];
    int e_data   [MAXC];
    int e_rden   [MAXC];
    int e_rdaddr [MAXC];
    int done_c;
    int done_seen;
    int img      [MAXC];
    int wcount   [MAXC];

    // Bin store: registered read, data valid the cycle after the strobe.
    always @(posedge wrclk) begin
        if (bus_a.bin_rd_en) bus_a.bin_rd_data <= MW'(bins_a[bus_a.bin_rd_addr]);
        if (bus_b.bin_rd_en) bus_b.bin_rd_data <= MW'(bins_b[bus_b.bin_rd_addr]);
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s observed %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic setStart(input int sel, input logic v);
        if (sel == 1) bus_b.start = v;
        else          bus_a.start = v;
    endtask

    task automatic clearPeaks();
        for (int b = 0; b < NB; b++) begin
            peaks_a[b] = 0;
            peaks_b[b] = 0;
        end
    endtask

    // Expected frame: one fetch+latch per bar, then that bar's columns top to bottom.
    task automatic buildModel(input int sel);
        int w;
        int bw;
        int c;
        int xlast;
        int bb;
        int mags [NB];
        int pk [NB];
        bit inb;
        w  = (sel == 1) ? WB : WA;
        bw = w / NB;
        for (int b = 0; b < NB; b++) begin
            int raw;
            raw     = (sel == 1) ? bins_b[b] : bins_a[b];
            mags[b] = (raw > H) ? H : raw;
            pk[b]   = 0;
`ifdef RENDER_PEAK_EN
            begin
                int old;
                int dec;
                old   = (sel == 1) ? peaks_b[b] : peaks_a[b];
                dec   = (old > 0) ? old - 1 : 0;
                pk[b] = (mags[b] > dec) ? mags[b] : dec;
                if (sel == 1) peaks_b[b] = pk[b];
                else          peaks_a[b] = pk[b];
            end
`endif
        end
        for (int i = 0; i < MAXC; i++) begin
            e_wen[i] = 0; e_addr[i] = 0; e_data[i] = 0; e_rden[i] = 0; e_rdaddr[i] = 0;
        end
        c = 1;
        for (int b = 0; b < NB; b++) begin
            e_rden[c]   = 1;
            e_rdaddr[c] = b;
            c += 2;
            xlast = (b == NB-1) ? w - 1 : (b + 1) * bw - 1;
            for (int x = b * bw; x <= xlast; x++) begin
                for (int y = 0; y < H; y++) begin
                    inb = (x < NB * bw) && ((x % bw) < bw - GAP);
                    bb  = (x / bw < NB) ? x / bw : NB - 1;
                    e_wen[c]  = 1;
                    e_addr[c] = y * w + x;
                    e_data[c] = int'(inb && ((y >= H - mags[bb]) ||
                                             (pk[bb] > 0 && y == H - pk[bb])));
                    c++;
                end
            end
        end
        done_c = c;
    endtask

    // Runs one frame on the selected DUT; optional stray start and mid-frame reset cycles.
    task automatic applyStimulus(input int sel, input int b0, input int b1,
                                 input int extra_start, input int reset_cyc,
                                 output int lit_count);
        int w;
        int o_busy, o_done, o_rden, o_rdaddr, o_wen, o_addr, o_data;
        w = (sel == 1) ? WB : WA;
        if (sel == 1) begin bins_b[0] = b0; bins_b[1] = b1; end
        else          begin bins_a[0] = b0; bins_a[1] = b1; end
        buildModel(sel);
        lit_count = 0;
        done_seen = -1;
        for (int i = 0; i < MAXC; i++) begin
            img[i] = 0;
            wcount[i] = 0;
        end
        @(negedge wrclk);
        setStart(sel, 1'b1);
        @(negedge wrclk);
        setStart(sel, 1'b0);
        for (int c = 1; c <= done_c + 2; c++) begin
            if (c > 1) @(negedge wrclk);
            setStart(sel, (c == extra_start) ? 1'b1 : 1'b0);
            if (c == reset_cyc) begin
                reset = 1'b1;
                #1;
                checkOutput("rst_wen",  (sel == 1) ? bus_b.wr_en : bus_a.wr_en, 0);
                checkOutput("rst_busy", (sel == 1) ? bus_b.busy : bus_a.busy, 0);
                checkOutput("rst_done", (sel == 1) ? bus_b.done : bus_a.done, 0);
                checkOutput("rst_rden", (sel == 1) ? bus_b.bin_rd_en : bus_a.bin_rd_en, 0);
                @(negedge wrclk);
                reset = 1'b0;
                setStart(sel, 1'b0);
                clearPeaks();
                for (int k = 0; k < done_c; k++) begin
                    @(negedge wrclk);
                    checkOutput("post_rst_busy", (sel == 1) ? bus_b.busy : bus_a.busy, 0);
                    checkOutput("post_rst_done", (sel == 1) ? bus_b.done : bus_a.done, 0);
                end
                return;
            end
            o_busy   = int'((sel == 1) ? bus_b.busy : bus_a.busy);
            o_done   = int'((sel == 1) ? bus_b.done : bus_a.done);
            o_rden   = int'((sel == 1) ? bus_b.bin_rd_en : bus_a.bin_rd_en);
            o_rdaddr = int'((sel == 1) ? bus_b.bin_rd_addr : bus_a.bin_rd_addr);
            o_wen    = int'((sel == 1) ? bus_b.wr_en : bus_a.wr_en);
            o_addr   = (sel == 1) ? int'(bus_b.wr_addr) : int'(bus_a.wr_addr);
            o_data   = int'((sel == 1) ? bus_b.wr_data : bus_a.wr_data);
            checkOutput("busy", o_busy, (c <= done_c) ? 1 : 0);
            checkOutput("done", o_done, (c == done_c) ? 1 : 0);
            checkOutput("rd_en", o_rden, e_rden[c]);
            checkOutput("wr_en", o_wen, e_wen[c]);
            if (e_rden[c] == 1) checkOutput("rd_addr", o_rdaddr, e_rdaddr[c]);
            if (e_wen[c] == 1) begin
                checkOutput("wr_addr", o_addr, e_addr[c]);
                checkOutput("wr_data", o_data, e_data[c]);
            end
            if (o_done == 1 && done_seen < 0) done_seen = c;
            if (o_wen == 1 && o_addr < w * H) begin
                wcount[o_addr]++;
                img[o_addr] = o_data;
                lit_count += o_data;
            end
        end
        for (int a = 0; a < w * H; a++) begin
            checkOutput("write_once", wcount[a], 1);
        end
    endtask

    task automatic pulseReset();
        @(negedge wrclk);
        reset = 1'b1;
        @(negedge wrclk);
        @(negedge wrclk);
        reset = 1'b0;
        clearPeaks();
    endtask

    initial begin
        int lit;
        int tp1_lit [18];
        bit in_list;
        tp1_lit = '{16, 17, 18, 24, 25, 26, 4, 5, 6, 12, 13, 14, 20, 21, 22, 28, 29, 30};
        reset = 1'b1;
        bus_a.start = 1'b0;
        bus_b.start = 1'b0;
        bus_a.bin_rd_data = '0;
        bus_b.bin_rd_data = '0;
        clearPeaks();
        for (int b = 0; b < NB; b++) begin
            bins_a[b] = 0;
            bins_b[b] = 0;
        end
        repeat (3) @(negedge wrclk);
        checkOutput("reset_busy",    bus_a.busy, 0);
        checkOutput("reset_done",    bus_a.done, 0);
        checkOutput("reset_rd_en",   bus_a.bin_rd_en, 0);
        checkOutput("reset_rd_addr", 32'(bus_a.bin_rd_addr), 0);
        checkOutput("reset_wr_en",   bus_a.wr_en, 0);
        checkOutput("reset_wr_addr", 32'(bus_a.wr_addr), 0);
        checkOutput("reset_wr_data", bus_a.wr_data, 0);
        checkOutput("reset_b_busy",  bus_b.busy, 0);
        reset = 1'b0;

        $display("[TB] frame 8x4 bins 2,9");
        applyStimulus(0, 2, 9, 0, 0, lit);
        checkOutput("tp1_done_cycle", done_seen, 37);
        checkOutput("tp1_lit_count", lit, 18);
        for (int a = 0; a < WA * H; a++) begin
            in_list = 1'b0;
            for (int i = 0; i < 18; i++) begin
                if (tp1_lit[i] == a) in_list = 1'b1;
            end
            checkOutput("tp1_image", img[a], int'(in_list));
        end

        $display("[TB] zero bins with stray start");
        applyStimulus(0, 0, 0, 10, 0, lit);
        checkOutput("tp3_lit_count", lit, 0);
        checkOutput("tp3_done_cycle", done_seen, 37);

        $display("[TB] reset mid-draw");
        applyStimulus(0, $urandom_range(0, 15), $urandom_range(0, 15), 0, 12, lit);
        applyStimulus(0, 3, 1, 0, 0, lit);
        checkOutput("tp4_done_cycle", done_seen, 37);

        $display("[TB] frame 10x4 bins 4,4 with start on done");
        applyStimulus(1, 4, 4, 45, 0, lit);
        checkOutput("tp5_done_cycle", done_seen, 45);
        for (int y = 0; y < H; y++) begin
            checkOutput("tp5_col4", img[y * WB + 4], 0);
            checkOutput("tp5_col9", img[y * WB + 9], 0);
        end

        $display("[TB] random frames");
        for (int n = 0; n < 8; n++) begin
            int sel;
            sel = int'($urandom_range(0, 1));
            applyStimulus(sel, $urandom_range(0, 15), $urandom_range(0, 15),
                          $urandom_range(0, 1) == 1 ? int'($urandom_range(2, 30)) : 0, 0, lit);
        end

        $display("[TB] peak hold sequence");
        pulseReset();
        applyStimulus(0, 3, 0, 0, 0, lit);
        applyStimulus(0, 0, 0, 0, 0, lit);
`ifdef RENDER_PEAK_EN
        checkOutput("tp6_lit_count", lit, 3);
        checkOutput("tp6_px16", img[16], 1);
        checkOutput("tp6_px17", img[17], 1);
        checkOutput("tp6_px18", img[18], 1);
`else
        checkOutput("tp6_lit_count", lit, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
